// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampled UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } rx_state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  // Clock divider for one oversample tick, rounded to nearest, never zero.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned os);
    int unsigned den;
    den      = baud * os;
    calc_div = (clk_hz + den / 2) / den;
    if (calc_div == 0) calc_div = 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead FIFO with explicit level tracking; head word is zero when empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign level_o = level_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver (parity none/even/odd, 1 or 2 stop bits) feeding a show-ahead FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic                          rx_serial,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic                          rd_req,
  input  logic                          ovr_clr,
  output logic                          rd_valid,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_parity_err,
  output logic                          rd_frame_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam int unsigned ENT_W = DATA_BITS + 2;

  logic [2:0]           sync_q;
  logic                 rx_s, fall;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic                 tick, restart, bit_tick;
  rx_state_t            state_q, state_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [1:0]           par_mode_q, par_mode_d;
  logic                 stop2_q, stop2_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 push_q, push_d;
  logic                 ovr_q, ovr_d;
  logic                 fifo_full, fifo_empty;
  logic [ENT_W-1:0]     fifo_dout;

  // sync_q[1] is the synchronised line, sync_q[2] its previous value for edge detection.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) sync_q <= 3'b111;
    else                sync_q <= {sync_q[1:0], rx_serial};
  end

  assign rx_s      = sync_q[1];
  assign fall      = sync_q[2] & ~sync_q[1];
  assign tick      = (div_cnt_q == DIV_W'(DIV - 1));
  assign bit_tick  = tick && (os_cnt_q == OS_W'(OVERSAMPLE - 1));
  assign div_cnt_d = (restart || tick) ? '0 : div_cnt_q + DIV_W'(1);

  always_comb begin
    state_d    = state_q;
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    par_mode_d = par_mode_q;
    stop2_d    = stop2_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    push_d     = 1'b0;
    restart    = 1'b0;
    if (tick && state_q != IDLE) os_cnt_d = bit_tick ? '0 : os_cnt_q + OS_W'(1);
    case (state_q)
      IDLE: begin
        if (fall) begin
          restart  = 1'b1;
          os_cnt_d = '0;
          state_d  = START;
        end
      end
      START: begin
        if (tick && os_cnt_q == OS_W'(OVERSAMPLE / 2 - 1)) begin
          os_cnt_d = '0;
          if (!rx_s) begin
            par_mode_d = (cfg_parity == PAR_EVEN || cfg_parity == PAR_ODD) ? cfg_parity : PAR_NONE;
            stop2_d    = cfg_stop2;
            bit_cnt_d  = '0;
            perr_d     = 1'b0;
            ferr_d     = 1'b0;
            state_d    = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (bit_tick) begin
          data_d    = {rx_s, data_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1))
            state_d = (par_mode_q == PAR_NONE) ? STOP1 : PARITY;
        end
      end
      PARITY: begin
        if (bit_tick) begin
          perr_d  = (par_mode_q == PAR_ODD) ? ~(^data_q ^ rx_s) : (^data_q ^ rx_s);
          state_d = STOP1;
        end
      end
      STOP1: begin
        if (bit_tick) begin
          ferr_d = ~rx_s;
          if (stop2_q) begin
            state_d = STOP2;
          end else begin
            push_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      STOP2: begin
        if (bit_tick) begin
          ferr_d  = ferr_q | ~rx_s;
          push_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A drop sets overrun with priority over a simultaneous clear.
  always_comb begin
    ovr_d = ovr_q;
    if (ovr_clr) ovr_d = 1'b0;
    if (push_q && fifo_full && !rd_req) ovr_d = 1'b1;
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      div_cnt_q  <= '0;
      state_q    <= IDLE;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      par_mode_q <= PAR_NONE;
      stop2_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      push_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      state_q    <= state_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      par_mode_q <= par_mode_d;
      stop2_q    <= stop2_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      push_q     <= push_d;
      ovr_q      <= ovr_d;
    end
  end

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_clk),
    .rst_ni  (reset_reset_n),
    .push_i  (push_q),
    .data_i  ({ferr_q, perr_q, data_q}),
    .pop_i   (rd_req),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign rd_valid = ~fifo_empty;
  assign {rd_frame_err, rd_parity_err, rd_data} = fifo_dout;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised self-checking bench for uart_rx_fifo against a queue-based frame model.
module tb_uart_rx_fifo;

  localparam int BIT = 160;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } ent_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;
  logic       rd_req;
  logic       ovr_clr;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_parity_err;
  logic       rd_frame_err;
  logic [3:0] fifo_level;
  logic       overrun;

  int   n_run  = 0;
  int   n_fail = 0;
  ent_t mq[$];
  logic m_ovr;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_HZ     (1600000),
    .BAUD       (10000),
    .OVERSAMPLE (16),
    .DATA_BITS  (8),
    .FIFO_DEPTH (8)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .rx_serial     (rx),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .rd_req        (rd_req),
    .ovr_clr       (ovr_clr),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_parity_err (rd_parity_err),
    .rd_frame_err  (rd_frame_err),
    .fifo_level    (fifo_level),
    .overrun       (overrun)
  );

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model: a frame yields one entry, or sets overrun when eight entries are held.
  task automatic model_frame(input logic [7:0] d, input logic [1:0] pm, input logic pbit,
                             input logic s1, input logic s2, input logic two);
    ent_t e;
    e.d  = d;
    e.pe = (pm == 2'b01) ? ((^d) ^ pbit) : (pm == 2'b10) ? ~((^d) ^ pbit) : 1'b0;
    e.fe = ~s1 | (two & ~s2);
    if (mq.size() == 8) m_ovr = 1'b1;
    else                mq.push_back(e);
  endtask

  // Drives one complete frame; cfg is scrambled after the start bit to prove it is latched.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic pbit,
                            input logic s1, input logic s2, input logic two);
    cfg_parity = pm;
    cfg_stop2  = two;
    rx = 1'b1;
    wait_cyc(20);
    rx = 1'b0;
    wait_cyc(BIT);
    cfg_parity = 2'($urandom_range(3));
    cfg_stop2  = 1'($urandom_range(1));
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cyc(BIT);
    end
    if (pm == 2'b01 || pm == 2'b10) begin
      rx = pbit;
      wait_cyc(BIT);
    end
    rx = s1;
    wait_cyc(BIT);
    if (two) begin
      rx = s2;
      wait_cyc(BIT);
    end
    rx = 1'b1;
    model_frame(d, pm, pbit, s1, s2, two);
  endtask

  task automatic pop_one();
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx = 1'b1; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    rd_req = 1'b0; ovr_clr = 1'b0; m_ovr = 1'b0; mq.delete();
    wait_cyc(4);
    rst_n = 1'b1;
    wait_cyc(4);
    n_run++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", rd_valid); end
    n_run++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", rd_data); end
    n_run++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_run++; if (overrun !== 1'b0 || rd_parity_err !== 1'b0 || rd_frame_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got ovr=%b pe=%b fe=%b want 0", overrun, rd_parity_err, rd_frame_err); end
  endtask

  task automatic test_basic_8n1();
    send_frame(8'hA5, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    n_run++; if (rd_valid !== 1'b1 || fifo_level !== 4'd1) begin
      n_fail++; $display("FAIL basic_level: got valid=%b level=%0d want 1/1", rd_valid, fifo_level); end
    n_run++; if (rd_data !== mq[0].d || rd_parity_err !== mq[0].pe || rd_frame_err !== mq[0].fe) begin
      n_fail++; $display("FAIL basic_head: got %h/%b/%b want %h/%b/%b", rd_data, rd_parity_err, rd_frame_err, mq[0].d, mq[0].pe, mq[0].fe); end
    pop_one();
    n_run++; if (rd_valid !== 1'b0 || fifo_level !== 4'd0 || rd_data !== 8'h00) begin
      n_fail++; $display("FAIL basic_pop: got valid=%b level=%0d data=%h want 0/0/00", rd_valid, fifo_level, rd_data); end
    pop_one();
    n_run++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL pop_empty: got level %0d want 0", fifo_level); end
  endtask

  task automatic test_parity();
    send_frame(8'h03, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h03, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0);
    send_frame(8'h03, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0);
    n_run++; if (fifo_level !== 4'd3) begin n_fail++; $display("FAIL parity_level: got %0d want 3", fifo_level); end
    for (int i = 0; i < 3; i++) begin
      n_run++; if (rd_data !== mq[0].d || rd_parity_err !== mq[0].pe || rd_frame_err !== mq[0].fe) begin
        n_fail++; $display("FAIL parity_entry%0d: got %h/pe=%b/fe=%b want %h/pe=%b/fe=%b", i, rd_data, rd_parity_err, rd_frame_err, mq[0].d, mq[0].pe, mq[0].fe); end
      pop_one();
    end
  endtask

  task automatic test_framing();
    send_frame(8'h55, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
    rx = 1'b0;
    wait_cyc(20 * BIT);
    rx = 1'b1;
    wait_cyc(2 * BIT);
    n_run++; if (fifo_level !== 4'd1) begin n_fail++; $display("FAIL frame_low_level: got %0d want 1", fifo_level); end
    n_run++; if (rd_data !== 8'h55 || rd_frame_err !== 1'b1 || rd_parity_err !== 1'b0) begin
      n_fail++; $display("FAIL frame_low_head: got %h/fe=%b/pe=%b want 55/1/0", rd_data, rd_frame_err, rd_parity_err); end
    pop_one();
    send_frame(8'h81, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1);
    n_run++; if (rd_data !== mq[0].d || rd_frame_err !== mq[0].fe || fifo_level !== 4'd1) begin
      n_fail++; $display("FAIL frame_stop2: got %h/fe=%b/lvl=%0d want %h/fe=%b/lvl=1", rd_data, rd_frame_err, fifo_level, mq[0].d, mq[0].fe); end
    pop_one();
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    n_run++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL ovr_level: got %0d want 8", fifo_level); end
    n_run++; if (overrun !== m_ovr) begin n_fail++; $display("FAIL ovr_flag: got %b want %b", overrun, m_ovr); end
    for (int i = 0; i < 8; i++) begin
      n_run++; if (rd_data !== mq[0].d) begin n_fail++; $display("FAIL ovr_pop%0d: got %h want %h", i, rd_data, mq[0].d); end
      pop_one();
    end
    n_run++; if (rd_valid !== 1'b0 || overrun !== 1'b1) begin
      n_fail++; $display("FAIL ovr_drain: got valid=%b ovr=%b want 0/1", rd_valid, overrun); end
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    m_ovr = 1'b0;
    n_run++; if (overrun !== m_ovr) begin n_fail++; $display("FAIL ovr_clear: got %b want %b", overrun, m_ovr); end
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    wait_cyc(40);
    rx = 1'b1;
    wait_cyc(2 * BIT);
    n_run++; if (fifo_level !== 4'd0 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL glitch_nopush: got level=%0d valid=%b want 0/0", fifo_level, rd_valid); end
    send_frame(8'h3C, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    n_run++; if (fifo_level !== 4'd1 || rd_data !== 8'h3C || rd_frame_err !== 1'b0) begin
      n_fail++; $display("FAIL glitch_after: got lvl=%0d data=%h fe=%b want 1/3c/0", fifo_level, rd_data, rd_frame_err); end
    pop_one();
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    b = 8'h3C;
    send_frame(8'h11, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    rx = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      wait_cyc(BIT);
    end
    wait_cyc(BIT / 2);
    rst_n = 1'b0;
    #1;
    mq.delete(); m_ovr = 1'b0;
    n_run++; if (rd_valid !== 1'b0 || rd_data !== 8'h00 || fifo_level !== 4'd0 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_async: got valid=%b data=%h lvl=%0d ovr=%b want all 0", rd_valid, rd_data, fifo_level, overrun); end
    rx = 1'b1;
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(BIT);
    n_run++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL rst_mid_nopush: got %0d want 0", fifo_level); end
    send_frame(8'h3C, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    n_run++; if (fifo_level !== 4'd1 || rd_data !== 8'h3C || rd_parity_err !== 1'b0 || rd_frame_err !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_after: got lvl=%0d %h/%b/%b want 1 3c/0/0", fifo_level, rd_data, rd_parity_err, rd_frame_err); end
    pop_one();
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic [1:0] pm;
    logic pb, s1, s2, two;
    for (int k = 0; k < 10; k++) begin
      d   = 8'($urandom);
      pm  = 2'($urandom_range(3));
      pb  = 1'($urandom_range(1));
      s1  = ($urandom_range(3) != 0);
      s2  = ($urandom_range(3) != 0);
      two = 1'($urandom_range(1));
      send_frame(d, pm, pb, s1, s2, two);
      n_run++; if (fifo_level !== 4'(mq.size()) || overrun !== m_ovr) begin
        n_fail++; $display("FAIL rand%0d_level: got lvl=%0d ovr=%b want %0d/%b", k, fifo_level, overrun, mq.size(), m_ovr); end
      n_run++; if (rd_data !== mq[0].d || rd_parity_err !== mq[0].pe || rd_frame_err !== mq[0].fe) begin
        n_fail++; $display("FAIL rand%0d_head: got %h/%b/%b want %h/%b/%b", k, rd_data, rd_parity_err, rd_frame_err, mq[0].d, mq[0].pe, mq[0].fe); end
      if (mq.size() >= 3 || $urandom_range(1) == 1) pop_one();
    end
    while (mq.size() > 0) begin
      n_run++; if (rd_data !== mq[0].d) begin n_fail++; $display("FAIL rand_drain: got %h want %h", rd_data, mq[0].d); end
      pop_one();
    end
    n_run++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rand_empty: got valid %b want 0", rd_valid); end
  endtask

  initial begin
    test_reset();
    test_basic_8n1();
    test_parity();
    test_framing();
    test_overrun();
    test_glitch();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised successor to the fixed 8-bit RS-232 receive path feeding the Nios PIO (rx data, parity flag, read handshake). Oversampled UART receiver with runtime-selectable parity (none/even/odd) and 1 or 2 stop bits. Per-frame parity and framing error flags. Show-ahead receive FIFO with sticky overrun, so the CPU polls a queue instead of a single byte.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 9600, line bit rate
OVERSAMPLE, 16, sample ticks per bit; even, >=8
DATA_BITS, 8, data bits per frame; 5..9
FIFO_DEPTH, 8, entries; power of two, >=2

Ports:
clk_clk  in  1  system clock
reset_reset_n  in  1  asynchronous active-low reset
rx_serial  in  1  asynchronous serial line, idle high
cfg_parity  in  2  00 none, 01 even, 10 odd, 11 treated as none
cfg_stop2  in  1  1 = two stop bits checked
rd_req  in  1  one-cycle pop of the FIFO head
ovr_clr  in  1  clears the overrun flag
rd_valid  out  1  FIFO not empty
rd_data  out  DATA_BITS  head entry data
rd_parity_err  out  1  head entry parity error
rd_frame_err  out  1  head entry framing error
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held
overrun  out  1  sticky: a frame was dropped because the FIFO was full

Behaviour:
- Reset: all outputs 0; FSM IDLE; FIFO empty; tick counter 0; synchroniser flops preset to 1 (idle line). Asserting reset mid-frame aborts the frame immediately; no partial push.
- rx_serial passes through a 2-flop synchroniser, then an edge-detect flop. Only the synchronised value is used.
- Tick generator: DIV = round(CLK_HZ/(BAUD*OVERSAMPLE)), 1-cycle tick every DIV clocks. It free-runs and is restarted at start-edge detection.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE -> START on a synchronised 1->0 edge. A line held low never re-triggers.
  - START: after OVERSAMPLE/2 ticks, sample the line. If low, latch cfg_parity and cfg_stop2 for this frame, then go to DATA. If high (glitch), return to IDLE with no push.
  - DATA: sample every OVERSAMPLE ticks, LSB first, DATA_BITS samples. Then go to PARITY if the latched mode is even/odd, else STOP1.
  - PARITY: one sample p. Even: error = ^data ^ p. Odd: error = ~(^data ^ p). None: error 0.
  - STOP1: one sample; low sets frame_err. Then STOP2 if the latched stop2 is set, else push and go to IDLE.
  - STOP2: one sample; low also sets frame_err. Then push and go to IDLE.
- Config changes mid-frame have no effect until the next start bit.
- Push occurs on the cycle after the final stop sample. rd_valid, rd_data and fifo_level reflect it one cycle later.
- FIFO entry = {frame_err, parity_err, data}. Frames with errors are still stored.
- FIFO is show-ahead: rd_data and the flags always show the head entry. rd_data is 0 when empty.
- rd_req pops the head on that clock edge. rd_req while empty is ignored and level stays 0.
- Push and pop in the same cycle:
  - FIFO full: both occur, level unchanged, no overrun.
  - FIFO empty: push stored, pop ignored, level becomes 1.
- Push while full without pop: frame dropped, FIFO contents untouched, overrun set.
- Overrun clears on ovr_clr. If a new drop and ovr_clr fall in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH. Level is tracked separately, so full and empty are unambiguous.

Decomposition:
- Package uart_pkg holds:
  - rx_state_t enum (IDLE, START, DATA, PARITY, STOP1, STOP2)
  - parity constants PAR_NONE=2'b00, PAR_EVEN=2'b01, PAR_ODD=2'b10
  - helper function computing DIV from CLK_HZ, BAUD and OVERSAMPLE
- One sub-module, sync_fifo: show-ahead FIFO parametrised by WIDTH and DEPTH, exposing push, pop, full, empty, level. The receiver FSM, synchroniser and tick generator stay in uart_rx_fifo.

Test Plan:
Bench uses CLK_HZ=1600000, BAUD=10000, OVERSAMPLE=16, so DIV=10 and one bit = 160 cycles.
1. Reset, cfg 8N1, send 0xA5 -> within 1 cycle after the stop sample + 1: rd_valid=1, rd_data=0xA5, both errs 0, level 1. Pulse rd_req -> rd_valid=0, level 0.
2. Even parity: 0x03 with parity bit 0 -> parity_err=0. Then 0x03 with parity bit 1 -> second entry parity_err=1. Odd mode with 0x03 and parity bit 1 -> parity_err=0.
3. 8N1 frame 0x55 with stop bit low, line then held low for 2 frame times -> exactly one entry: 0x55, frame_err=1. cfg_stop2=1 with second stop low -> frame_err=1.
4. Send 9 frames 0x01..0x09 without reading -> level 8, overrun=1, head 0x01. Pop 8 -> data sequence 0x01..0x08. ovr_clr -> overrun=0.
5. Low glitch of 40 cycles (less than half a bit) -> no entry, FSM back in IDLE. A valid 0x3C sent afterwards is received correctly.
6. Assert reset_reset_n=0 midway through a frame's data bits -> outputs 0 asynchronously. Release and send 0x3C -> single entry 0x3C, no errors.
